sm2_kdf_xor: RTL and testbench
==============================

// Module: sm2_kdf_xor
// PURPOSE
//  Downstream consumer of the SM2 KDF stage: forms C2 = M xor t, with t = KDF key stream (klen bits).
//  Latches 1024-bit key block on kin_valid, optionally rejects all-zero t (SM2 rule), then streams
//  message in 32-bit words and emits masked ciphertext words with valid/ready handshakes.
//  Feeds the C1||C2||C3 assembly / SM3 C3 stage.
// PARAMETERS
//  KLEN_MAX  1024  max supported klen in bits; equals key input width; multiple of 32
//  DW        32    message/ciphertext word width (fixed; other values unsupported)
// PORTS
//  clk         in   1     single clock, rising edge
//  rstn        in   1     asynchronous active-low reset
//  kin         in   1024  key stream; kin[1023] = first key bit; word i = kin[1023-32*i -: 32]
//  kin_valid   in   1     1-cycle pulse; sampled only in IDLE
//  klen        in   32    key/message length in bits, sampled with kin_valid
//  msg_data    in   32    message word, MSB-first
//  msg_valid   in   1     message word present
//  msg_ready   out  1     block accepts msg word this cycle
//  dout_data   out  32    ciphertext word; unused low bits of last word forced 0
//  dout_valid  out  1     ciphertext word present
//  dout_last   out  1     qualifies final ciphertext word
//  dout_ready  in   1     downstream accepts dout word
//  busy        out  1     high in any state except IDLE
//  done        out  1     1-cycle pulse at end of job (success or error)
//  t_zero      out  1     t was all-zero over klen bits; held until next accepted kin_valid
//  len_err     out  1     klen==0 or klen>KLEN_MAX; held until next accepted kin_valid
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal key/klen/counters 0. Reset mid-job aborts, no done.
//  nw = (klen+31)>>5; rem = klen[4:0]; mask = all-ones for words < nw-1, last word mask =
//   rem==0 ? 32'hFFFFFFFF : ~(32'hFFFFFFFF >> rem). Word counter w is 6 bits (0..31).
//  States: IDLE, ZCHK, XOR, DRAIN, DONE.
//  IDLE: on kin_valid latch kin,klen; clear t_zero,len_err. Bad klen -> DONE with len_err=1.
//   Else -> ZCHK (macro on) or XOR (macro off), w=0. kin_valid outside IDLE ignored.
//  ZCHK: one word/cycle, acc |= key_word(w) & mask(w); after w=nw-1: acc==0 -> DONE, t_zero=1,
//   no msg word consumed; else -> XOR, w=0. Latency = nw cycles.
//  XOR: msg_ready = !dout_valid | dout_ready (one-entry output register, no bubble under full flow).
//   On msg_valid&msg_ready: next cycle dout_data=(msg_data^key_word(w))&mask(w), dout_valid=1,
//   dout_last=(w==nw-1); w++. After accepting word nw-1 -> DRAIN.
//  dout_valid held with stable data/last until dout_ready; cleared on take if no new word loaded.
//  DRAIN: msg_ready=0; wait until dout_valid=0 (last word taken) -> DONE.
//  DONE: done=1 one cycle -> IDLE. msg_ready=0 in every state but XOR.
//  Throughput 1 word/cycle; input-to-output latency 1 cycle.
// CONFIGURATION
//  SM2_KDF_XOR_ZCHK_EN defined: ZCHK state built, all-zero t aborts with t_zero=1.
//  Undefined: ZCHK omitted, IDLE -> XOR directly, t_zero tied 0 (caller owns the check).
// TESTING
//  klen=256, kin upper 256 bits = 0x11..11, msg words 0xFFFFFFFF x8, dout_ready=1 ->
//   8 words 0xEEEEEEEE, dout_last on 8th, done 1 cycle after last taken, t_zero=len_err=0.
//  klen=100, kin[1023:924]=all ones, msg=0 x4 -> dout 0xFFFFFFFF x3 then 0xF0000000 with last.
//  klen=64, dout_ready toggled 1/0 each cycle -> dout_data stable while stalled, no word lost/dup.
//  klen=128, kin=0 (macro on) -> after 4 ZCHK cycles done=1, t_zero=1, msg_ready never high.
//  klen=0 and klen=1025 -> done next cycle, len_err=1, no dout_valid.
//  rstn low during XOR after 2 of 8 words -> all outputs 0 immediately, IDLE; new job runs clean.

Source files
------------

// File: rtl/sm2_kdf_xor_if.sv
// Message-in / ciphertext-out stream bundle for sm2_kdf_xor.
interface sm2_kdf_xor_if;
   localparam int unsigned DW = 32;

   logic [DW-1:0] msg_data;
   logic          msg_valid;
   logic          msg_ready;
   logic [DW-1:0] dout_data;
   logic          dout_valid;
   logic          dout_last;
   logic          dout_ready;

   modport slave (
      input  msg_data, msg_valid, dout_ready,
      output msg_ready, dout_data, dout_valid, dout_last
   );

   modport master (
      output msg_data, msg_valid, dout_ready,
      input  msg_ready, dout_data, dout_valid, dout_last
   );
endinterface

// File: rtl/sm2_kdf_xor.sv
// SM2 C2 = M xor t: latches a KDF key block, then masks the 32-bit message stream word by word.
// Optional all-zero t rejection is built when SM2_KDF_XOR_ZCHK_EN is defined.
module sm2_kdf_xor #(
   parameter int unsigned KLEN_MAX = 1024,
   parameter int unsigned DW       = 32
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [KLEN_MAX-1:0] kin,
   input  logic                kin_valid,
   input  logic [31:0]         klen,
   sm2_kdf_xor_if.slave        bus,
   output logic                busy,
   output logic                done,
   output logic                t_zero,
   output logic                len_err
);
   localparam int unsigned NW_MAX = KLEN_MAX / DW;
   localparam int unsigned WI_W   = $clog2(NW_MAX);
   localparam int unsigned DW_L   = $clog2(DW);
   localparam int unsigned KL_W   = $clog2(KLEN_MAX) + 1;

   typedef enum logic [2:0] {S_IDLE, S_ZCHK, S_XOR, S_DRAIN, S_DONE} state_t;

   state_t              state;
   logic [KLEN_MAX-1:0] key;
   logic [KL_W-1:0]     klen_q;
   logic [WI_W:0]       w;
   logic [DW-1:0]       dout_data_q;
   logic                dout_valid_q;
   logic                dout_last_q;

   logic [WI_W-1:0]     last_idx;
   logic [DW_L-1:0]     rem;
   logic                is_last;
   logic [DW-1:0]       key_w;
   logic [DW-1:0]       mask_w;
   logic                len_bad;
   logic                msg_ready_c;
   logic                msg_fire;

   // Word index of the last word is (klen-1)/DW; klen is known non-zero once latched.
   assign last_idx    = WI_W'((klen_q - KL_W'(1)) >> DW_L);
   assign rem         = klen_q[DW_L-1:0];
   assign is_last     = (w == {1'b0, last_idx});
   assign key_w       = key[{WI_W'(NW_MAX - 1) - w[WI_W-1:0], DW_L'(0)} +: DW];
   assign mask_w      = (is_last && rem != '0) ? ~({DW{1'b1}} >> rem) : {DW{1'b1}};
   assign len_bad     = (klen == 32'd0) || (klen > 32'(KLEN_MAX));
   // One-entry output register: accept a new word whenever the current one leaves.
   assign msg_ready_c = (state == S_XOR) && (!dout_valid_q || bus.dout_ready);
   assign msg_fire    = msg_ready_c && bus.msg_valid;

   assign bus.msg_ready  = msg_ready_c;
   assign bus.dout_data  = dout_data_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_last  = dout_last_q;

`ifdef SM2_KDF_XOR_ZCHK_EN
   logic [DW-1:0] acc;
   logic [DW-1:0] acc_nxt;
   assign acc_nxt = acc | (key_w & mask_w);
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         key          <= '0;
         klen_q       <= '0;
         w            <= '0;
         dout_data_q  <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         t_zero       <= 1'b0;
         len_err      <= 1'b0;
`ifdef SM2_KDF_XOR_ZCHK_EN
         acc          <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (dout_valid_q && bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (kin_valid) begin
                  key     <= kin;
                  klen_q  <= klen[KL_W-1:0];
                  t_zero  <= 1'b0;
                  len_err <= 1'b0;
                  w       <= '0;
                  busy    <= 1'b1;
                  if (len_bad) begin
                     len_err <= 1'b1;
                     done    <= 1'b1;
                     state   <= S_DONE;
                  end else begin
`ifdef SM2_KDF_XOR_ZCHK_EN
                     acc   <= '0;
                     state <= S_ZCHK;
`else
                     state <= S_XOR;
`endif
                  end
               end
            end
`ifdef SM2_KDF_XOR_ZCHK_EN
            S_ZCHK: begin
               acc <= acc_nxt;
               if (is_last) begin
                  w <= '0;
                  if (acc_nxt == '0) begin
                     t_zero <= 1'b1;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     state <= S_XOR;
                  end
               end else begin
                  w <= w + (WI_W + 1)'(1);
               end
            end
`endif
            S_XOR: begin
               if (msg_fire) begin
                  dout_data_q  <= (bus.msg_data ^ key_w) & mask_w;
                  dout_valid_q <= 1'b1;
                  dout_last_q  <= is_last;
                  w            <= w + (WI_W + 1)'(1);
                  if (is_last) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!dout_valid_q) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sm2_kdf_xor.sv
// Self-checking bench for sm2_kdf_xor: directed vectors plus randomized jobs against a bit-level model.
module tb_sm2_kdf_xor;
   typedef logic [31:0] wq_t[$];
   typedef bit          bq_t[$];

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [1023:0] kin;
   logic          kin_valid;
   logic [31:0]   klen;
   logic          busy, done, t_zero, len_err;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   sm2_kdf_xor_if bus ();

   sm2_kdf_xor dut (
      .clk(clk), .rstn(rstn), .kin(kin), .kin_valid(kin_valid), .klen(klen),
      .bus(bus), .busy(busy), .done(done), .t_zero(t_zero), .len_err(len_err)
   );

   // Stream bit g (0 = first) of C2 is M bit g xor t bit g, zero past klen.
   function automatic logic [31:0] model_word(input logic [1023:0] k, input int unsigned kl,
                                               input int i, input logic [31:0] m);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         int unsigned g;
         g = 32'(32 * i + b);
         if (g < kl) r[31-b] = m[31-b] ^ k[1023-g];
      end
      return r;
   endfunction

   function automatic logic [1023:0] rand_key();
      logic [1023:0] k;
      for (int i = 0; i < 32; i++) k[i*32 +: 32] = $urandom();
      return k;
   endfunction

   task automatic run_job(input logic [1023:0] k, input logic [31:0] kl, input wq_t m,
                          input int rmode, output wq_t od, output bq_t ol,
                          output int c_done, output int c_last, output int mready_cnt,
                          output int viol);
      int idx; bit stall; bit tgl; logic [31:0] pd; logic pl;
      od = {}; ol = {}; c_done = -1; c_last = -1; mready_cnt = 0; viol = 0;
      idx = 0; stall = 0; tgl = 1; pd = '0; pl = 1'b0;
      @(negedge clk);
      kin = k; klen = kl; kin_valid = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         kin_valid = 1'b0;
         if (done) begin c_done = c; break; end
         if (stall && (bus.dout_valid !== 1'b1 || bus.dout_data !== pd || bus.dout_last !== pl))
            viol++;
         case (rmode)
            0: bus.dout_ready = 1'b1;
            1: begin bus.dout_ready = tgl; tgl = !tgl; end
            default: bus.dout_ready = ($urandom_range(0, 2) != 0);
         endcase
         bus.msg_valid = (idx < m.size()) && (rmode != 2 || $urandom_range(0, 3) != 0);
         bus.msg_data  = (idx < m.size()) ? m[idx] : 32'h0;
         #1;
         if (bus.msg_valid && bus.msg_ready) idx++;
         if (bus.msg_ready) mready_cnt++;
         if (bus.dout_valid && bus.dout_ready) begin
            od.push_back(bus.dout_data);
            ol.push_back(bus.dout_last);
            c_last = c;
         end
         stall = bus.dout_valid && !bus.dout_ready;
         pd = bus.dout_data; pl = bus.dout_last;
      end
      bus.msg_valid = 1'b0;
      bus.dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({bus.msg_ready, bus.dout_valid, bus.dout_last, busy, done, t_zero, len_err} !== 7'b0) begin
         errors++; $display("FAIL reset_flags got=%b exp=0000000",
            {bus.msg_ready, bus.dout_valid, bus.dout_last, busy, done, t_zero, len_err});
      end
      checks++; if (bus.dout_data !== 32'h0) begin
         errors++; $display("FAIL reset_dout_data got=%h exp=00000000", bus.dout_data);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vec256();
      logic [1023:0] k; wq_t m, od; bq_t ol; int cd, cl, mr, vi;
      k = rand_key();
      k[1023:768] = {8{32'h11111111}};
      m = {};
      for (int i = 0; i < 8; i++) m.push_back(32'hFFFFFFFF);
      run_job(k, 32'd256, m, 0, od, ol, cd, cl, mr, vi);
      checks++; if (od.size() != 8) begin errors++; $display("FAIL v256_count got=%0d exp=8", od.size()); end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++; if (od[i] !== 32'hEEEEEEEE || ol[i] !== (i == 7)) begin
            errors++; $display("FAIL v256_word%0d got=%h/%0d exp=eeeeeeee/%0d", i, od[i], ol[i], i == 7);
         end
      end
      checks++; if (cd < 0 || cd - cl != 2) begin
         errors++; $display("FAIL v256_done_timing got=%0d exp=2 (done=%0d)", cd - cl, cd);
      end
      checks++; if (t_zero !== 1'b0 || len_err !== 1'b0) begin
         errors++; $display("FAIL v256_status got=%b%b exp=00", t_zero, len_err);
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL v256_done_pulse got=done%b busy%b exp=00", done, busy);
      end
   endtask

   task automatic test_vec100();
      logic [1023:0] k; wq_t m, od; bq_t ol; int cd, cl, mr, vi;
      logic [31:0] exp_w [4];
      exp_w[0] = 32'hFFFFFFFF; exp_w[1] = 32'hFFFFFFFF; exp_w[2] = 32'hFFFFFFFF; exp_w[3] = 32'hF0000000;
      k = rand_key();
      k[1023:924] = '1;
      m = {32'h0, 32'h0, 32'h0, 32'h0};
      run_job(k, 32'd100, m, 0, od, ol, cd, cl, mr, vi);
      checks++; if (od.size() != 4 || cd < 0) begin
         errors++; $display("FAIL v100_count got=%0d exp=4 (done=%0d)", od.size(), cd);
      end
      for (int i = 0; i < 4 && i < od.size(); i++) begin
         checks++; if (od[i] !== exp_w[i] || ol[i] !== (i == 3)) begin
            errors++; $display("FAIL v100_word%0d got=%h/%0d exp=%h/%0d", i, od[i], ol[i], exp_w[i], i == 3);
         end
      end
   endtask

   task automatic test_stall64();
      logic [1023:0] k; wq_t m, od; bq_t ol; int cd, cl, mr, vi;
      k = rand_key();
      m = {$urandom(), $urandom()};
      run_job(k, 32'd64, m, 1, od, ol, cd, cl, mr, vi);
      checks++; if (od.size() != 2 || cd < 0) begin
         errors++; $display("FAIL stall_count got=%0d exp=2 (done=%0d)", od.size(), cd);
      end
      for (int i = 0; i < 2 && i < od.size(); i++) begin
         checks++; if (od[i] !== model_word(k, 64, i, m[i]) || ol[i] !== (i == 1)) begin
            errors++; $display("FAIL stall_word%0d got=%h exp=%h", i, od[i], model_word(k, 64, i, m[i]));
         end
      end
      checks++; if (vi != 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0 violations", vi); end
   endtask

   task automatic test_zero();
      wq_t m, od; bq_t ol; int cd, cl, mr, vi;
      m = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_job('0, 32'd128, m, 0, od, ol, cd, cl, mr, vi);
`ifdef SM2_KDF_XOR_ZCHK_EN
      checks++; if (cd != 4) begin errors++; $display("FAIL zero_latency got=%0d exp=4", cd); end
      checks++; if (t_zero !== 1'b1 || len_err !== 1'b0) begin
         errors++; $display("FAIL zero_flag got=%b%b exp=10", t_zero, len_err);
      end
      checks++; if (mr != 0 || od.size() != 0) begin
         errors++; $display("FAIL zero_no_msg got=ready%0d out%0d exp=0/0", mr, od.size());
      end
      @(negedge clk);
      checks++; if (t_zero !== 1'b1) begin errors++; $display("FAIL zero_held got=%b exp=1", t_zero); end
`else
      checks++; if (od.size() != 4 || cd < 0) begin
         errors++; $display("FAIL zero_count got=%0d exp=4 (done=%0d)", od.size(), cd);
      end
      for (int i = 0; i < 4 && i < od.size(); i++) begin
         checks++; if (od[i] !== m[i]) begin errors++; $display("FAIL zero_word%0d got=%h exp=%h", i, od[i], m[i]); end
      end
      checks++; if (t_zero !== 1'b0) begin errors++; $display("FAIL zero_flag got=%b exp=0", t_zero); end
`endif
   endtask

   task automatic test_len_err();
      logic [31:0] bad [2];
      wq_t m, od; bq_t ol; int cd, cl, mr, vi;
      bad[0] = 32'd0; bad[1] = 32'd1025;
      for (int j = 0; j < 2; j++) begin
         m = {$urandom(), $urandom()};
         run_job(rand_key(), bad[j], m, 0, od, ol, cd, cl, mr, vi);
         checks++; if (cd != 0) begin errors++; $display("FAIL lenerr%0d_latency got=%0d exp=0", bad[j], cd); end
         checks++; if (len_err !== 1'b1 || t_zero !== 1'b0) begin
            errors++; $display("FAIL lenerr%0d_flag got=%b%b exp=10", bad[j], len_err, t_zero);
         end
         checks++; if (od.size() != 0 || mr != 0) begin
            errors++; $display("FAIL lenerr%0d_quiet got=out%0d ready%0d exp=0/0", bad[j], od.size(), mr);
         end
         @(negedge clk);
         checks++; if (len_err !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL lenerr%0d_held got=err%b done%b exp=10", bad[j], len_err, done);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [1023:0] k; wq_t m, od; bq_t ol; int cd, cl, mr, vi; int taken; int idx;
      k = rand_key(); taken = 0; idx = 0;
      @(negedge clk);
      kin = k; klen = 32'd256; kin_valid = 1'b1;
      for (int c = 0; c < 200 && taken < 2; c++) begin
         @(negedge clk);
         kin_valid = 1'b0;
         bus.dout_ready = 1'b1;
         bus.msg_valid = 1'b1;
         bus.msg_data = $urandom();
         #1;
         if (bus.dout_valid && bus.dout_ready) taken++;
      end
      checks++; if (taken != 2) begin errors++; $display("FAIL rstmid_progress got=%0d exp=2", taken); end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++; if ({bus.msg_ready, bus.dout_valid, bus.dout_last, busy, done, t_zero, len_err} !== 7'b0
                    || bus.dout_data !== 32'h0) begin
         errors++; $display("FAIL rstmid_outputs got=%b/%h exp=0000000/00000000",
            {bus.msg_ready, bus.dout_valid, bus.dout_last, busy, done, t_zero, len_err}, bus.dout_data);
      end
      bus.msg_valid = 1'b0; bus.dout_ready = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      k = rand_key(); m = {};
      for (int i = 0; i < 8; i++) m.push_back($urandom());
      run_job(k, 32'd256, m, 0, od, ol, cd, cl, mr, vi);
      checks++; if (od.size() != 8 || cd < 0) begin
         errors++; $display("FAIL rstmid_rerun_count got=%0d exp=8 (done=%0d)", od.size(), cd);
      end
      for (int i = 0; i < 8 && i < od.size(); i++) begin
         checks++; if (od[i] !== model_word(k, 256, i, m[i]) || ol[i] !== (i == 7)) begin
            errors++; $display("FAIL rstmid_word%0d got=%h exp=%h", i, od[i], model_word(k, 256, i, m[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [1023:0] k; wq_t m, od; bq_t ol; int cd, cl, mr, vi; int unsigned kl; int nw;
      for (int it = 0; it < 8; it++) begin
         kl = (it == 0) ? 1 : (it == 1) ? 1024 : (it == 2) ? 33 : $urandom_range(1, 1024);
         nw = int'((kl + 31) / 32);
         k = rand_key(); m = {};
         for (int i = 0; i < nw; i++) m.push_back($urandom());
         run_job(k, kl, m, 2, od, ol, cd, cl, mr, vi);
         checks++; if (od.size() != nw || cd < 0) begin
            errors++; $display("FAIL rand%0d_count klen=%0d got=%0d exp=%0d (done=%0d)", it, kl, od.size(), nw, cd);
         end
         for (int i = 0; i < nw && i < od.size(); i++) begin
            checks++; if (od[i] !== model_word(k, kl, i, m[i]) || ol[i] !== (i == nw - 1)) begin
               errors++; $display("FAIL rand%0d_word%0d klen=%0d got=%h/%0d exp=%h/%0d", it, i, kl,
                                  od[i], ol[i], model_word(k, kl, i, m[i]), i == nw - 1);
            end
         end
         checks++; if (vi != 0 || t_zero !== 1'b0 || len_err !== 1'b0) begin
            errors++; $display("FAIL rand%0d_status got=viol%0d tz%b le%b exp=0/0/0", it, vi, t_zero, len_err);
         end
      end
   endtask

   initial begin
      kin = '0; kin_valid = 1'b0; klen = '0;
      bus.msg_data = '0; bus.msg_valid = 1'b0; bus.dout_ready = 1'b0;
      test_reset();
      test_vec256();
      test_vec100();
      test_stall64();
      test_zero();
      test_len_err();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
